// File: rtl/tie_level_monitor.sv
// tie_level_monitor
//   Receive-side checker for tie-low / tie-high cells. Every enabled cycle
//   the monitored bus is compared against a per-bit expected constant.
//   A mismatch must persist for DEBOUNCE consecutive armed cycles before a
//   sticky fault is declared. Each declared fault bumps a saturating
//   event counter. A level/pulse clear handshake drops the fault and
//   re-enters the settle window.
//
// Optional build macro: TIEMON_CAPTURE_EN
//   When defined, adds FIRST_BAD, a capture of the mismatch vector that
//   caused the fault.
//
// Ports
//   CLK        clock, rising edge
//   RST        synchronous active-high reset; beats every other input
//   Y_IN       monitored tie nets
//   EN         monitor enable; 0 holds state, counters, FAULT, MISMATCH
//   CLR_REQ    clear request level, held until CLR_ACK
//   CLR_ACK    one-cycle acknowledge of an accepted clear
//   ARMED      comparison active (ARMED or FAULTED state)
//   FAULT      sticky fault flag
//   MISMATCH   registered Y_IN ^ EXPECT, updated on enabled cycles
//   FAULT_CNT  saturating count of declared faults
//   DBG_STATE  current FSM state (0 settling, 1 armed, 2 faulted)
//   FIRST_BAD  (TIEMON_CAPTURE_EN only) mismatch vector at the fault edge
//
// Handshake: a clear is accepted on an edge where CLR_REQ=1, CLR_ACK=0
// and CLR_REQ has been observed low since the previous accept (or since
// reset). The accepting edge raises CLR_ACK for exactly one cycle.

module tie_level_monitor #(
  parameter int              WIDTH    = 8,
  parameter logic [WIDTH-1:0] EXPECT  = '0,
  parameter int              SETTLE   = 4,
  parameter int              DEBOUNCE = 3,
  parameter int              CNT_W    = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] Y_IN,
  input  logic             EN,
  input  logic             CLR_REQ,
  output logic             CLR_ACK,
  output logic             ARMED,
  output logic             FAULT,
  output logic [WIDTH-1:0] MISMATCH,
  output logic [CNT_W-1:0] FAULT_CNT,
`ifdef TIEMON_CAPTURE_EN
  output logic [WIDTH-1:0] FIRST_BAD,
`endif
  output logic [1:0]       DBG_STATE
);

  localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  typedef enum logic [1:0] {
    ST_SETTLING = 2'd0,
    ST_ARMED    = 2'd1,
    ST_FAULTED  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [SC_W-1:0]   settle_cnt;
  logic [DB_W-1:0]   deb_cnt;
  logic              clr_rearm;   // CLR_REQ seen low since last accept
  logic [WIDTH-1:0]  mis_vec;
  logic              m;
  logic              clr_accept;
  logic              settle_done;
  logic              deb_hit;
  logic              fault_event;

  // Comparison uses the live XOR, not the registered MISMATCH copy.
  assign mis_vec     = Y_IN ^ EXPECT;
  assign m           = |mis_vec;
  assign clr_accept  = CLR_REQ && !CLR_ACK && clr_rearm;
  assign settle_done = (settle_cnt == SC_W'(SETTLE - 1));
  assign deb_hit     = m && (deb_cnt == DB_W'(DEBOUNCE - 1));
  // A clear on the same edge wins over a fault: no transition, no count.
  assign fault_event = EN && (state == ST_ARMED) && deb_hit && !clr_accept;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_SETTLING;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (clr_accept) begin
      state_nxt = ST_SETTLING;
    end else if (EN) begin
      case (state)
        ST_SETTLING: if (settle_done) state_nxt = ST_ARMED;
        ST_ARMED:    if (deb_hit)     state_nxt = ST_FAULTED;
        ST_FAULTED:  state_nxt = ST_FAULTED;
        default:     state_nxt = ST_SETTLING;
      endcase
    end
  end

  // Output logic
  always_comb begin
    ARMED     = (state != ST_SETTLING);
    FAULT     = (state == ST_FAULTED);
    DBG_STATE = state;
  end

  // Counters, handshake and mismatch register
  always_ff @(posedge CLK) begin
    if (RST) begin
      settle_cnt <= '0;
      deb_cnt    <= '0;
      FAULT_CNT  <= '0;
      CLR_ACK    <= 1'b0;
      clr_rearm  <= 1'b1;
      MISMATCH   <= '0;
    end else begin
      CLR_ACK <= clr_accept;
      if (clr_accept)    clr_rearm <= 1'b0;
      else if (!CLR_REQ) clr_rearm <= 1'b1;

      if (EN) MISMATCH <= mis_vec;

      if (clr_accept) begin
        settle_cnt <= '0;
        deb_cnt    <= '0;
      end else if (EN) begin
        case (state)
          ST_SETTLING: begin
            if (!settle_done) settle_cnt <= settle_cnt + SC_W'(1);
            deb_cnt <= '0;
          end
          ST_ARMED: begin
            if (!m || deb_hit) deb_cnt <= '0;
            else               deb_cnt <= deb_cnt + DB_W'(1);
          end
          default: deb_cnt <= '0;
        endcase
      end

      if (fault_event && (FAULT_CNT != {CNT_W{1'b1}}))
        FAULT_CNT <= FAULT_CNT + CNT_W'(1);
    end
  end

`ifdef TIEMON_CAPTURE_EN
  // The FSM only leaves FAULTED through clear or reset, so every fault
  // event is the first one since the last reset/clear.
  always_ff @(posedge CLK) begin
    if (RST)              FIRST_BAD <= '0;
    else if (clr_accept)  FIRST_BAD <= '0;
    else if (fault_event) FIRST_BAD <= mis_vec;
  end
`endif

endmodule

// File: tb/tb_tie_level_monitor.sv
module tb_tie_level_monitor;

  logic       CLK;
  logic       RST;
  logic [7:0] Y_IN;
  logic       EN;
  logic       CLR_REQ;

  logic       ack_a, armed_a, fault_a;
  logic [7:0] mis_a, cnt_a;
  logic [1:0] dbg_a;
  logic       ack_s, armed_s, fault_s;
  logic [7:0] mis_s;
  logic [1:0] cnt_s;
  logic [1:0] dbg_s;
`ifdef TIEMON_CAPTURE_EN
  logic [7:0] fb_a, fb_s;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  tie_level_monitor u_dut (
    .CLK(CLK), .RST(RST), .Y_IN(Y_IN), .EN(EN), .CLR_REQ(CLR_REQ),
    .CLR_ACK(ack_a), .ARMED(armed_a), .FAULT(fault_a), .MISMATCH(mis_a),
    .FAULT_CNT(cnt_a),
`ifdef TIEMON_CAPTURE_EN
    .FIRST_BAD(fb_a),
`endif
    .DBG_STATE(dbg_a)
  );

  tie_level_monitor #(.CNT_W(2)) u_sat (
    .CLK(CLK), .RST(RST), .Y_IN(Y_IN), .EN(EN), .CLR_REQ(CLR_REQ),
    .CLR_ACK(ack_s), .ARMED(armed_s), .FAULT(fault_s), .MISMATCH(mis_s),
    .FAULT_CNT(cnt_s),
`ifdef TIEMON_CAPTURE_EN
    .FIRST_BAD(fb_s),
`endif
    .DBG_STATE(dbg_s)
  );

  // ---------------- driver tasks ----------------
  // Advance one edge and settle past it; outputs are sampled 1 ns later.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_counts(input string tag, input int k);
    check({tag, "_cnt"}, 32'(cnt_a), 32'(k));
    check({tag, "_sat_cnt"}, 32'(cnt_s), 32'((k > 3) ? 3 : k));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    RST = 1'b1; EN = 1'b0; Y_IN = 8'h00; CLR_REQ = 1'b0;
    step(2);
    check("rst_fault", 32'(fault_a), 32'd0);
    check("rst_armed", 32'(armed_a), 32'd0);
    check("rst_ack",   32'(ack_a),   32'd0);
    check("rst_mis",   32'(mis_a),   32'h00);
    check("rst_cnt",   32'(cnt_a),   32'd0);
    check("rst_state", 32'(dbg_a),   32'd0);

    // Settle: ARMED appears on the 4th enabled edge after reset falls
    RST = 1'b0; EN = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step(1);
      check($sformatf("settle_armed_%0d", i), 32'(armed_a), 32'd0);
    end
    step(1);
    check("settle_armed_4", 32'(armed_a), 32'd1);
    check("settle_fault",   32'(fault_a), 32'd0);
    check("settle_cnt",     32'(cnt_a),   32'd0);
    check("settle_state",   32'(dbg_a),   32'd1);

    // Glitch rejection: 2 mismatch cycles below DEBOUNCE=3
    Y_IN = 8'h01;
    step(1);
    check("glitch_mis_1", 32'(mis_a), 32'h01);
    step(1);
    check("glitch_mis_2",   32'(mis_a),   32'h01);
    check("glitch_fault_2", 32'(fault_a), 32'd0);
    Y_IN = 8'h00;
    step(1);
    check("glitch_mis_3",   32'(mis_a),   32'h00);
    check("glitch_fault_3", 32'(fault_a), 32'd0);

    // Fault on the 3rd consecutive mismatch edge
    Y_IN = 8'h10;
    step(2);
    check("fault_early", 32'(fault_a), 32'd0);
    step(1);
    check("fault_set",   32'(fault_a), 32'd1);
    check("fault_mis",   32'(mis_a),   32'h10);
    check_counts("fault1", 1);
`ifdef TIEMON_CAPTURE_EN
    check("fault_first_bad", 32'(fb_a), 32'h10);
`endif
    step(20);
    check("hold_cnt",   32'(cnt_a),   32'd1);
    check("hold_fault", 32'(fault_a), 32'd1);
    check("hold_armed", 32'(armed_a), 32'd1);

    // EN=0 freezes MISMATCH and FAULT
    EN = 1'b0; Y_IN = 8'h04;
    step(2);
    check("freeze_mis",   32'(mis_a),   32'h10);
    check("freeze_fault", 32'(fault_a), 32'd1);

    // Clear handshake: CLR_REQ held 5 cycles, single ACK on the first edge
    EN = 1'b1; Y_IN = 8'h00; CLR_REQ = 1'b1;
    step(1);
    check("clr_ack",   32'(ack_a),   32'd1);
    check("clr_fault", 32'(fault_a), 32'd0);
    check("clr_armed", 32'(armed_a), 32'd0);
    check("clr_cnt",   32'(cnt_a),   32'd1);
    for (int i = 2; i <= 4; i++) begin
      step(1);
      check($sformatf("clr_ack_%0d", i),   32'(ack_a),   32'd0);
      check($sformatf("clr_armed_%0d", i), 32'(armed_a), 32'd0);
    end
    step(1);
    check("clr_ack_5",   32'(ack_a),   32'd0);
    check("clr_rearmed", 32'(armed_a), 32'd1);
    check("clr_cnt_5",   32'(cnt_a),   32'd1);
    CLR_REQ = 1'b0;

    // Fault/clear cycles 2..5: sat instance goes 2,3,3,3
    for (int k = 2; k <= 5; k++) begin
      Y_IN = 8'h24;
      step(3);
      check($sformatf("loop%0d_fault", k), 32'(fault_a), 32'd1);
      check_counts($sformatf("loop%0d", k), k);
`ifdef TIEMON_CAPTURE_EN
      check($sformatf("loop%0d_first_bad", k), 32'(fb_a), 32'h24);
`endif
      Y_IN = 8'h00; CLR_REQ = 1'b1;
      step(1);
      check($sformatf("loop%0d_ack", k), 32'(ack_a), 32'd1);
`ifdef TIEMON_CAPTURE_EN
      check($sformatf("loop%0d_first_bad_clr", k), 32'(fb_a), 32'h00);
`endif
      CLR_REQ = 1'b0;
      step(4);
      check($sformatf("loop%0d_rearmed", k), 32'(armed_a), 32'd1);
    end

    // Clear and fault on the same edge: clear wins, no count
    Y_IN = 8'h24;
    step(2);
    CLR_REQ = 1'b1;
    step(1);
    check("race_ack",   32'(ack_a),   32'd1);
    check("race_fault", 32'(fault_a), 32'd0);
    check("race_armed", 32'(armed_a), 32'd0);
    check_counts("race", 5);
    CLR_REQ = 1'b0;

    // Mismatch during settling is ignored; then fault on 8'h24
    step(4);
    check("settle_ignore_armed", 32'(armed_a), 32'd1);
    check("settle_ignore_fault", 32'(fault_a), 32'd0);
    step(3);
    check("mid_fault", 32'(fault_a), 32'd1);
    check_counts("mid", 6);
`ifdef TIEMON_CAPTURE_EN
    check("mid_first_bad", 32'(fb_a), 32'h24);
`endif

    // Reset mid-fault
    RST = 1'b1;
    step(1);
    check("rst2_fault", 32'(fault_a), 32'd0);
    check("rst2_armed", 32'(armed_a), 32'd0);
    check("rst2_mis",   32'(mis_a),   32'h00);
    check_counts("rst2", 0);
`ifdef TIEMON_CAPTURE_EN
    check("rst2_first_bad", 32'(fb_a), 32'h00);
`endif

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
